// File: rtl/alu_issue_stage.sv
// Purpose: EX issue/retire around a combinational ALU: decode ID instr -> stage A (ALU operands) -> stage B (EX/MEM).
// Latency: accepted at edge N -> operands on alu_* after N, result on ex_result/ex_valid after N+1.
// Backpressure: mem_ready stalls B, then A, then id_ready; one instruction per cycle with no stalls.
module alu_issue_stage #(
    parameter int          XLEN      = 32,
    parameter logic [3:0]  RESET_CTL = 4'h0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [5:0]       id_opcode,
    input  logic [5:0]       id_funct,
    input  logic [4:0]       id_shamt,
    input  logic [15:0]      id_imm,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic [XLEN-1:0]  id_rs_val,
    input  logic [XLEN-1:0]  id_rt_val,
    output logic [XLEN-1:0]  alu_in1,
    output logic [XLEN-1:0]  alu_in2,
    output logic [3:0]       alu_ctrl,
    input  logic [XLEN-1:0]  alu_out,
    output logic             ex_valid,
    input  logic             mem_ready,
    output logic [XLEN-1:0]  ex_result,
    output logic [4:0]       ex_dest,
    output logic             ex_illegal
);

    localparam logic [3:0] CTL_AND     = 4'b0000;
    localparam logic [3:0] CTL_OR      = 4'b0001;
    localparam logic [3:0] CTL_ADD     = 4'b0010;
    localparam logic [3:0] CTL_SRL     = 4'b0011;
    localparam logic [3:0] CTL_SUB     = 4'b0110;
    localparam logic [3:0] CTL_SLT     = 4'b0111;
    localparam logic [3:0] CTL_XOR     = 4'b1001;
    localparam logic [3:0] CTL_SLL     = 4'b1010;
    localparam logic [3:0] CTL_SRA     = 4'b1011;
    localparam logic [3:0] CTL_NOR     = 4'b1100;
    localparam logic [3:0] CTL_SLTU    = 4'b1110;
    localparam logic [3:0] CTL_ILLEGAL = 4'b1111;

    // Stage A: operands currently presented to the ALU
    logic            a_valid_q, a_valid_d;
    logic [XLEN-1:0] a_in1_q, a_in1_d;
    logic [XLEN-1:0] a_in2_q, a_in2_d;
    logic [3:0]      a_ctrl_q, a_ctrl_d;
    logic [4:0]      a_dest_q, a_dest_d;
    logic            a_illegal_q, a_illegal_d;

    // Stage B: EX/MEM register
    logic            ex_valid_q, ex_valid_d;
    logic [XLEN-1:0] ex_result_q, ex_result_d;
    logic [4:0]      ex_dest_q, ex_dest_d;
    logic            ex_illegal_q, ex_illegal_d;

    // Decoder outputs for the instruction offered by ID
    logic [XLEN-1:0] dec_in1, dec_in2;
    logic [3:0]      dec_ctrl;
    logic [4:0]      dec_dest;
    logic            dec_illegal;

    logic [XLEN-1:0] imm_sext, imm_zext, shamt_zext;
    logic            b_free, a_move, id_accept, b_retire;

    assign imm_sext   = {{(XLEN-16){id_imm[15]}}, id_imm};
    assign imm_zext   = {{(XLEN-16){1'b0}}, id_imm};
    assign shamt_zext = {{(XLEN-5){1'b0}}, id_shamt};

    // A slot opens in B when it is empty or retiring; A can refill when empty or moving on.
    assign b_free    = !ex_valid_q || mem_ready;
    assign id_ready  = (!a_valid_q || b_free) && !flush && !rst;
    assign a_move    = a_valid_q && b_free;
    assign id_accept = id_valid && id_ready;
    assign b_retire  = ex_valid_q && mem_ready;

    // Decode opcode/funct into ALU control, operand selection and destination
    always_comb begin
        dec_illegal = 1'b0;
        dec_ctrl    = CTL_ILLEGAL;
        dec_in1     = id_rs_val;
        dec_in2     = id_rt_val;
        dec_dest    = id_rd;
        if (id_opcode == 6'h00) begin
            case (id_funct)
                6'h21: dec_ctrl = CTL_ADD;
                6'h23: dec_ctrl = CTL_SUB;
                6'h24: dec_ctrl = CTL_AND;
                6'h25: dec_ctrl = CTL_OR;
                6'h26: dec_ctrl = CTL_XOR;
                6'h27: dec_ctrl = CTL_NOR;
                6'h2A: dec_ctrl = CTL_SLT;
                6'h2B: dec_ctrl = CTL_SLTU;
                6'h00, 6'h02, 6'h03: begin
                    // Shifts take the value from rt and the amount from the shamt field
                    dec_in1 = id_rt_val;
                    dec_in2 = shamt_zext;
                    case (id_funct)
                        6'h00:   dec_ctrl = CTL_SLL;
                        6'h02:   dec_ctrl = CTL_SRL;
                        default: dec_ctrl = CTL_SRA;
                    endcase
                end
                default: dec_illegal = 1'b1;
            endcase
        end else begin
            dec_dest = id_rt;
            case (id_opcode)
                6'h09: begin dec_ctrl = CTL_ADD;  dec_in2 = imm_sext; end
                6'h0A: begin dec_ctrl = CTL_SLT;  dec_in2 = imm_sext; end
                6'h0B: begin dec_ctrl = CTL_SLTU; dec_in2 = imm_sext; end
                6'h0C: begin dec_ctrl = CTL_AND;  dec_in2 = imm_zext; end
                6'h0D: begin dec_ctrl = CTL_OR;   dec_in2 = imm_zext; end
                6'h0E: begin dec_ctrl = CTL_XOR;  dec_in2 = imm_zext; end
                6'h0F: begin
                    // lui is done on the ALU as imm << 16
                    dec_ctrl = CTL_SLL;
                    dec_in1  = imm_zext;
                    dec_in2  = XLEN'(16);
                end
                default: dec_illegal = 1'b1;
            endcase
        end
        if (dec_illegal) begin
            dec_ctrl = CTL_ILLEGAL;
            dec_in1  = '0;
            dec_in2  = '0;
            dec_dest = '0;
        end
    end

    // Stage A next state: load on accept, empty on move-without-accept, otherwise hold
    always_comb begin
        a_valid_d   = a_valid_q;
        a_in1_d     = a_in1_q;
        a_in2_d     = a_in2_q;
        a_ctrl_d    = a_ctrl_q;
        a_dest_d    = a_dest_q;
        a_illegal_d = a_illegal_q;
        if (id_accept) begin
            a_valid_d   = 1'b1;
            a_in1_d     = dec_in1;
            a_in2_d     = dec_in2;
            a_ctrl_d    = dec_ctrl;
            a_dest_d    = dec_dest;
            a_illegal_d = dec_illegal;
        end else if (a_move) begin
            // Operands hold; only the control code parks at its idle value
            a_valid_d = 1'b0;
            a_ctrl_d  = RESET_CTL;
        end
    end

    // Stage A register; flush kills the slot but leaves operand data in place
    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid_q   <= 1'b0;
            a_in1_q     <= '0;
            a_in2_q     <= '0;
            a_ctrl_q    <= RESET_CTL;
            a_dest_q    <= '0;
            a_illegal_q <= 1'b0;
        end else if (flush) begin
            a_valid_q   <= 1'b0;
            a_ctrl_q    <= RESET_CTL;
        end else begin
            a_valid_q   <= a_valid_d;
            a_in1_q     <= a_in1_d;
            a_in2_q     <= a_in2_d;
            a_ctrl_q    <= a_ctrl_d;
            a_dest_q    <= a_dest_d;
            a_illegal_q <= a_illegal_d;
        end
    end

    // Stage B next state: capture ALU result when A moves, clear valid on retire
    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_result_d  = ex_result_q;
        ex_dest_d    = ex_dest_q;
        ex_illegal_d = ex_illegal_q;
        if (a_move) begin
            ex_valid_d   = 1'b1;
            // Undecodable instructions retire with a zero result regardless of the ALU
            ex_result_d  = a_illegal_q ? '0 : alu_out;
            ex_dest_d    = a_dest_q;
            ex_illegal_d = a_illegal_q;
        end else if (b_retire) begin
            ex_valid_d   = 1'b0;
        end
    end

    // Stage B register; rst wins over flush
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q   <= 1'b0;
            ex_result_q  <= '0;
            ex_dest_q    <= '0;
            ex_illegal_q <= 1'b0;
        end else if (flush) begin
            ex_valid_q   <= 1'b0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_result_q  <= ex_result_d;
            ex_dest_q    <= ex_dest_d;
            ex_illegal_q <= ex_illegal_d;
        end
    end

    assign alu_in1    = a_in1_q;
    assign alu_in2    = a_in2_q;
    assign alu_ctrl   = a_ctrl_q;
    assign ex_valid   = ex_valid_q;
    assign ex_result  = ex_result_q;
    assign ex_dest    = ex_dest_q;
    assign ex_illegal = ex_illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Purpose: randomized + directed bench for alu_issue_stage with a scoreboard of instruction-level results.
// Latency: expected results queued at ID acceptance, popped by an independent monitor at each MEM handshake.
// Backpressure: mem_ready is held, released, or randomized to exercise stalls.
module tb_alu_issue_stage;

    localparam int         XLEN      = 32;
    localparam logic [3:0] RESET_CTL = 4'h0;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            id_valid;
    logic            id_ready;
    logic [5:0]      id_opcode;
    logic [5:0]      id_funct;
    logic [4:0]      id_shamt;
    logic [15:0]     id_imm;
    logic [4:0]      id_rt;
    logic [4:0]      id_rd;
    logic [XLEN-1:0] id_rs_val;
    logic [XLEN-1:0] id_rt_val;
    logic [XLEN-1:0] alu_in1;
    logic [XLEN-1:0] alu_in2;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] alu_out;
    logic            ex_valid;
    logic            mem_ready;
    logic [XLEN-1:0] ex_result;
    logic [4:0]      ex_dest;
    logic            ex_illegal;

    alu_issue_stage #(.XLEN(XLEN), .RESET_CTL(RESET_CTL)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_opcode(id_opcode), .id_funct(id_funct), .id_shamt(id_shamt),
        .id_imm(id_imm), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl), .alu_out(alu_out),
        .ex_valid(ex_valid), .mem_ready(mem_ready),
        .ex_result(ex_result), .ex_dest(ex_dest), .ex_illegal(ex_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment ALU; unknown codes give a junk value so the illegal-result zeroing is visible
    always_comb begin
        case (alu_ctrl)
            4'b0000: alu_out = alu_in1 & alu_in2;
            4'b0001: alu_out = alu_in1 | alu_in2;
            4'b0010: alu_out = alu_in1 + alu_in2;
            4'b0110: alu_out = alu_in1 - alu_in2;
            4'b1001: alu_out = alu_in1 ^ alu_in2;
            4'b1100: alu_out = ~(alu_in1 | alu_in2);
            4'b0111: alu_out = {31'b0, $signed(alu_in1) < $signed(alu_in2)};
            4'b1110: alu_out = {31'b0, alu_in1 < alu_in2};
            4'b1010: alu_out = alu_in1 << alu_in2[4:0];
            4'b0011: alu_out = alu_in1 >> alu_in2[4:0];
            4'b1011: alu_out = $unsigned($signed(alu_in1) >>> alu_in2[4:0]);
            default: alu_out = 32'hDEAD_BEEF;
        endcase
    end

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  dest;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   rand_mem = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Instruction-level semantics, independent of ALU codes
    function automatic exp_t ref_model(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                                       input logic [15:0] imm, input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [31:0] se;
        logic [31:0] ze;
        se = {{16{imm[15]}}, imm};
        ze = {16'h0, imm};
        e.ill = 1'b0;
        e.res = '0;
        e.dest = (op == 6'h00) ? rd : rt;
        if (op == 6'h00) begin
            case (fn)
                6'h21: e.res = a + b;
                6'h23: e.res = a - b;
                6'h24: e.res = a & b;
                6'h25: e.res = a | b;
                6'h26: e.res = a ^ b;
                6'h27: e.res = ~(a | b);
                6'h2A: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                6'h2B: e.res = (a < b) ? 32'd1 : 32'd0;
                6'h00: e.res = b << sh;
                6'h02: e.res = b >> sh;
                6'h03: e.res = $unsigned($signed(b) >>> sh);
                default: e.ill = 1'b1;
            endcase
        end else begin
            case (op)
                6'h09: e.res = a + se;
                6'h0A: e.res = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0;
                6'h0B: e.res = (a < se) ? 32'd1 : 32'd0;
                6'h0C: e.res = a & ze;
                6'h0D: e.res = a | ze;
                6'h0E: e.res = a ^ ze;
                6'h0F: e.res = {imm, 16'h0};
                default: e.ill = 1'b1;
            endcase
        end
        if (e.ill) begin
            e.res  = '0;
            e.dest = '0;
        end
        return e;
    endfunction

    // Monitor: every MEM handshake pops and compares the oldest expected result
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && ex_valid && mem_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_retire: got result 0x%0h, expected no retire", ex_result);
                end else begin
                    e = exp_q.pop_front();
                    check("ex_result", ex_result, e.res);
                    check("ex_dest", {27'b0, ex_dest}, {27'b0, e.dest});
                    check("ex_illegal", {31'b0, ex_illegal}, {31'b0, e.ill});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1);
    end

    // One cycle starting at a negedge: evaluate the ID handshake, record acceptance, go to next negedge
    task automatic tick(output bit acc);
        if (rand_mem) mem_ready = ($urandom_range(0, 3) != 0);
        #1;
        acc = id_valid && id_ready;
        if (acc)
            exp_q.push_back(ref_model(id_opcode, id_funct, id_shamt, id_imm, id_rt, id_rd, id_rs_val, id_rt_val));
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                             input logic [15:0] imm, input logic [31:0] a, input logic [31:0] b);
        id_opcode = op;
        id_funct  = fn;
        id_shamt  = sh;
        id_imm    = imm;
        id_rt     = 5'($urandom_range(0, 31));
        id_rd     = 5'($urandom_range(0, 31));
        id_rs_val = a;
        id_rt_val = b;
    endtask

    task automatic send(output int tries);
        bit acc;
        acc = 1'b0;
        tries = 0;
        id_valid = 1'b1;
        while (!acc && tries < 200) begin
            tick(acc);
            tries++;
        end
        id_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept, expected accept within 200 cycles");
        end
    endtask

    task automatic random_instr();
        logic [5:0] fns [11];
        logic [5:0] ops [7];
        logic [5:0] bad [4];
        int r;
        fns = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
        ops = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
        bad = '{6'h01, 6'h23, 6'h3F, 6'h10};
        r = $urandom_range(0, 19);
        if (r < 11)
            set_instr(6'h00, fns[r], 5'($urandom), 16'($urandom), $urandom, $urandom);
        else if (r < 18)
            set_instr(ops[r-11], 6'($urandom), 5'($urandom), 16'($urandom), $urandom, $urandom);
        else if (r == 18)
            set_instr(bad[$urandom_range(0, 3)], 6'($urandom), 5'($urandom), 16'($urandom), $urandom, $urandom);
        else
            set_instr(6'h00, 6'h3E, 5'($urandom), 16'($urandom), $urandom, $urandom);
    endtask

    task automatic drain();
        bit acc;
        int n;
        rand_mem  = 1'b0;
        mem_ready = 1'b1;
        id_valid  = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick(acc);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        bit acc;
        int tries;
        int n_acc;
        rst = 1'b1; flush = 1'b0; id_valid = 1'b0; mem_ready = 1'b0;
        set_instr(6'h00, 6'h00, 5'd0, 16'd0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);

        // Reset state
        #1;
        check("rst_id_ready", {31'b0, id_ready}, 32'd0);
        check("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        check("rst_alu_ctrl", {28'b0, alu_ctrl}, {28'b0, RESET_CTL});
        check("rst_alu_in1", alu_in1, 32'd0);
        check("rst_alu_in2", alu_in2, 32'd0);
        check("rst_ex_result", ex_result, 32'd0);
        check("rst_ex_dest", {27'b0, ex_dest}, 32'd0);
        check("rst_ex_illegal", {31'b0, ex_illegal}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // addu 5+7: operands and control one cycle after accept, then A empties to RESET_CTL
        mem_ready = 1'b1;
        set_instr(6'h00, 6'h21, 5'd0, 16'd0, 32'd5, 32'd7);
        id_rd = 5'd3;
        id_valid = 1'b1;
        tick(acc);
        id_valid = 1'b0;
        check("t1_accept", {31'b0, acc}, 32'd1);
        check("t1_alu_ctrl", {28'b0, alu_ctrl}, 32'b0010);
        check("t1_alu_in1", alu_in1, 32'd5);
        check("t1_alu_in2", alu_in2, 32'd7);
        tick(acc);
        check("t1_ex_valid", {31'b0, ex_valid}, 32'd1);
        check("t1_ex_result", ex_result, 32'd12);
        check("t1_ex_dest", {27'b0, ex_dest}, 32'd3);
        check("t1_ctrl_idle", {28'b0, alu_ctrl}, {28'b0, RESET_CTL});
        tick(acc);

        // Back-to-back 8: each accepted on its first cycle
        for (int i = 0; i < 8; i++) begin
            set_instr(6'h00, 6'h21, 5'd0, 16'd0, $urandom, $urandom);
            send(tries);
            check("b2b_tries", tries, 1);
        end
        drain();

        // Stall: mem_ready low for 5 cycles, only two fit
        mem_ready = 1'b0;
        n_acc = 0;
        random_instr();
        id_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(acc);
            if (acc) begin
                n_acc++;
                random_instr();
            end
        end
        check("stall_accepts", n_acc, 2);
        #1;
        check("stall_id_ready", {31'b0, id_ready}, 32'd0);
        @(negedge clk);
        mem_ready = 1'b1;
        send(tries);
        drain();

        // Directed corner instructions
        set_instr(6'h0F, 6'h00, 5'd0, 16'h1234, $urandom, $urandom);
        send(tries);
        set_instr(6'h00, 6'h03, 5'd4, 16'd0, $urandom, 32'h8000_0000);
        send(tries);
        set_instr(6'h3F, 6'h21, 5'd1, 16'hFFFF, 32'hFFFF_FFFF, 32'h1);
        send(tries);
        set_instr(6'h0A, 6'h00, 5'd0, 16'h0000, 32'hFFFF_FFFF, 32'h0);
        send(tries);
        set_instr(6'h0B, 6'h00, 5'd0, 16'h0000, 32'hFFFF_FFFF, 32'h0);
        send(tries);
        drain();

        // Flush with both stages full and ID offering
        mem_ready = 1'b0;
        random_instr();
        send(tries);
        random_instr();
        send(tries);
        check("pre_flush_ex_valid", {31'b0, ex_valid}, 32'd1);
        random_instr();
        flush = 1'b1;
        id_valid = 1'b1;
        #1;
        check("flush_id_ready", {31'b0, id_ready}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        id_valid = 1'b0;
        exp_q.delete();
        #1;
        check("flush_ex_valid", {31'b0, ex_valid}, 32'd0);
        check("flush_id_ready_after", {31'b0, id_ready}, 32'd1);
        @(negedge clk);
        mem_ready = 1'b1;
        tick(acc);
        check("flush_a_empty", {31'b0, ex_valid}, 32'd0);

        // Randomized stream with random backpressure
        rand_mem = 1'b1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) tick(acc);
            random_instr();
            send(tries);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
